// File: rtl/squeeze_serializer.sv
// squeeze_serializer: takes one squeezed rate block from the permute stage
// and streams it out as W-bit words over a valid/ready interface. The final
// block of a digest is trimmed to the requested output length. Unused low
// bits of the last word are zeroed, and dout_last/dout_bits mark the tail.
module squeeze_serializer #(
  parameter int RATE_MAX = 1344,
  parameter int W        = 64,
  parameter int SIZE_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RATE_MAX-1:0] block_data,
  input  logic [1:0]          block_mode,
  input  logic [SIZE_W-1:0]   block_size_left,
  input  logic                block_valid,
  output logic                block_ready,
  output logic [W-1:0]        dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic [6:0]          dout_bits,
  output logic                busy
);

  // Mode encodings shared with keccak_pkg (SHAKE128_MODE_VEC / SHAKE256_MODE_VEC)
  localparam logic [1:0] SHAKE128_MODE = 2'b00;
  localparam logic [1:0] SHAKE256_MODE = 2'b01;

  localparam int IDX_W = $clog2(RATE_MAX / W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    wt_q, wt_d;
  logic                final_q, final_d;
  logic [6:0]          tail_q, tail_d;
  logic [RATE_MAX-1:0] shift_q;

  logic [IDX_W-1:0]    blk_words;
  logic [SIZE_W-1:0]   blk_bits;
  logic [SIZE_W:0]     rnd_words;
  logic [IDX_W-1:0]    in_words;
  logic                in_final;
  logic [6:0]          in_tail;

  logic last_idx;
  logic hs;
  logic accept;
  logic load;

  // Keep only the top n bits of a word; the rest leave the core as zeros.
  function automatic logic [W-1:0] trim_word(input logic [W-1:0] w, input logic [6:0] n);
    logic [W-1:0] m;
    m = {W{1'b1}} << (W - int'(n));
    return w & m;
  endfunction

  // Decode the offered block: word count, last-block flag and tail width.
  always_comb begin
    case (block_mode)
      SHAKE128_MODE: blk_words = IDX_W'(1344 / W);
      SHAKE256_MODE: blk_words = IDX_W'(1088 / W);
      default:       blk_words = '0;
    endcase
    blk_bits  = SIZE_W'(blk_words) * SIZE_W'(W);
    // Only used when size_left < blk_bits, so the word count fits IDX_W.
    rnd_words = ({1'b0, block_size_left} + (SIZE_W + 1)'(W - 1)) / (SIZE_W + 1)'(W);
    in_words  = (block_size_left >= blk_bits) ? blk_words : IDX_W'(rnd_words);
    in_final  = (block_size_left <= blk_bits);
    in_tail   = 7'(block_size_left % SIZE_W'(W));
  end

  // Output stream, handshakes and the zero-bubble ready for the next block.
  always_comb begin
    last_idx   = (idx_q == wt_q - IDX_W'(1));
    dout_valid = (state_q == S_SEND);
    busy       = dout_valid;
    hs         = dout_valid & dout_ready;
    dout_last  = dout_valid & final_q & last_idx;
    dout_bits  = '0;
    dout       = '0;
    if (dout_valid) begin
      dout_bits = (dout_last && (tail_q != 7'd0)) ? tail_q : 7'(W);
      dout      = trim_word(shift_q[RATE_MAX-1 -: W], dout_bits);
    end
    block_ready = !rst && ((state_q == S_IDLE) || (hs && last_idx));
    accept      = block_valid & block_ready;
    load        = accept & (in_words != '0);
  end

  // Next-state: a non-empty accepted block always (re)starts at word 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wt_d    = wt_q;
    final_d = final_q;
    tail_d  = tail_q;
    if (load) begin
      state_d = S_SEND;
      idx_d   = '0;
      wt_d    = in_words;
      final_d = in_final;
      tail_d  = in_tail;
    end else if (hs) begin
      if (last_idx) begin
        state_d = S_IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Control registers, cleared asynchronously so a mid-block reset drops the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wt_q    <= '0;
      final_q <= 1'b0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wt_q    <= wt_d;
      final_q <= final_d;
      tail_q  <= tail_d;
    end
  end

  // Block shift register: MSB word is always the one on dout.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= block_data;
    end else if (hs) begin
      shift_q <= shift_q << W;
    end
  end

endmodule

// File: tb/tb_squeeze_serializer.sv
// Testbench for squeeze_serializer: directed block sequence with random
// data and random backpressure. It is checked against a word-list model
// built from the block rules at accept time.
module tb_squeeze_serializer;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1343:0] block_data = '0;
  logic [1:0]    block_mode = '0;
  logic [31:0]   block_size_left = '0;
  logic          block_valid = 1'b0;
  logic          block_ready;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic [6:0]    dout_bits;
  logic          busy;

  squeeze_serializer #(.RATE_MAX(1344), .W(64), .SIZE_W(32)) dut (
    .clk(clk), .rst(rst),
    .block_data(block_data), .block_mode(block_mode),
    .block_size_left(block_size_left), .block_valid(block_valid),
    .block_ready(block_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .dout_bits(dout_bits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [6:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_pct = 100;
  int   cyc = 0;
  int   hs_count = 0;
  int   last_hs_cyc = -1;
  int   gap_cnt = 0;
  bit   accepted = 0;
  bit   prev_stall = 0;
  logic [63:0] held_d;
  logic        held_l;
  logic [6:0]  held_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected words of one block, from the mode/size rules.
  task automatic model_push(input logic [1:0] mode, input logic [31:0] size, input logic [1343:0] data);
    longint bw, bits, nw, tail;
    bit fin;
    exp_t e;
    bw   = (mode == M128) ? 21 : (mode == M256) ? 17 : 0;
    bits = bw * 64;
    nw   = (longint'(size) >= bits) ? bw : (longint'(size) + 63) / 64;
    fin  = (longint'(size) <= bits);
    tail = longint'(size) % 64;
    for (int k = 0; k < nw; k++) begin
      e.d = data[1343 - 64*k -: 64];
      e.l = fin && (k == nw - 1);
      e.b = (e.l && tail != 0) ? 7'(tail) : 7'd64;
      for (int j = 0; j < 64 - int'(e.b); j++) e.d[j] = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // One clock: check at negedge, then advance and re-roll dout_ready.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (dout_valid) begin
      if (prev_stall) begin
        chk("stall_data", dout, held_d);
        chk("stall_last", {63'd0, dout_last}, {63'd0, held_l});
        chk("stall_bits", {57'd0, dout_bits}, {57'd0, held_b});
      end
      if (dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL extra_word observed=%0h expected=none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", dout, e.d);
          chk("word_last", {63'd0, dout_last}, {63'd0, e.l});
          chk("word_bits", {57'd0, dout_bits}, {57'd0, e.b});
        end
        hs_count++;
        if (last_hs_cyc >= 0 && cyc - last_hs_cyc != 1) gap_cnt++;
        last_hs_cyc = cyc;
      end
    end
    prev_stall = dout_valid && !dout_ready;
    held_d = dout; held_l = dout_last; held_b = dout_bits;
    if (block_valid && block_ready) begin
      model_push(block_mode, block_size_left, block_data);
      accepted = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    dout_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic send(input logic [1:0] mode, input logic [31:0] size, input logic [1343:0] data);
    int n;
    block_mode = mode; block_size_left = size; block_data = data;
    block_valid = 1'b1;
    accepted = 0;
    n = 0;
    while (!accepted && n < 200) begin
      tick();
      n++;
    end
    if (!accepted) begin
      checks++; errors++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted");
    end
    block_valid = 1'b0;
    block_data = '1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || dout_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_data(output logic [1343:0] d);
    for (int i = 0; i < 42; i++) d[32*i +: 32] = $urandom;
  endtask

  logic [1343:0] d1, d2;

  initial begin
    // Reset state, with an offered block that must not be accepted.
    block_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_block_ready", {63'd0, block_ready}, 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_dout_last", {63'd0, dout_last}, 64'd0);
    chk("rst_dout_bits", {57'd0, dout_bits}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    block_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_block_ready", {63'd0, block_ready}, 64'd1);

    // Full SHAKE128 block, ready held high: 21 consecutive words.
    ready_pct = 100; dout_ready = 1'b1;
    rand_data(d1);
    hs_count = 0; last_hs_cyc = -1; gap_cnt = 0;
    send(M128, 32'd1344, d1);
    drain();
    chk("s128_words", 64'(hs_count), 64'd21);
    chk("s128_gaps", 64'(gap_cnt), 64'd0);

    // SHAKE256, 100 bits: two words, second trimmed to 36 bits.
    rand_data(d1);
    hs_count = 0;
    send(M256, 32'd100, d1);
    drain();
    chk("s256_100_words", 64'(hs_count), 64'd2);
    tick();
    chk("s256_100_ready", {63'd0, block_ready}, 64'd1);

    // Back-to-back SHAKE256 blocks: 2000 then 912 bits, no bubble.
    rand_data(d1);
    rand_data(d2);
    hs_count = 0; last_hs_cyc = -1; gap_cnt = 0;
    send(M256, 32'd2000, d1);
    send(M256, 32'd912, d2);
    drain();
    chk("b2b_words", 64'(hs_count), 64'd32);
    chk("b2b_gaps", 64'(gap_cnt), 64'd0);

    // SHAKE128 under ~50% backpressure.
    ready_pct = 50;
    rand_data(d1);
    hs_count = 0;
    send(M128, 32'd1344, d1);
    drain();
    chk("bp_words", 64'(hs_count), 64'd21);

    // Reset after the 5th handshake: block discarded, next block starts at word 0.
    ready_pct = 100;
    rand_data(d1);
    hs_count = 0;
    send(M128, 32'd1344, d1);
    begin
      int n;
      n = 0;
      while (hs_count < 5 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("pre_rst_hs", 64'(hs_count), 64'd5);
    rst = 1'b1;
    #1;
    chk("midrst_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_block_ready", {63'd0, block_ready}, 64'd0);
    exp_q.delete();
    prev_stall = 0;
    tick();
    rst = 1'b0;
    rand_data(d2);
    hs_count = 0;
    send(M128, 32'd1344, d2);
    drain();
    chk("post_rst_words", 64'(hs_count), 64'd21);

    // Zero-size block and unknown mode: dropped, ready again next cycle.
    rand_data(d1);
    hs_count = 0;
    send(M256, 32'd0, d1);
    chk("zero_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("zero_block_ready", {63'd0, block_ready}, 64'd1);
    send(2'b11, 32'd1344, d1);
    chk("badmode_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("badmode_block_ready", {63'd0, block_ready}, 64'd1);
    repeat (3) tick();
    chk("dropped_words", 64'(hs_count), 64'd0);

    // Random modes and sizes with moderate backpressure.
    ready_pct = 70;
    for (int i = 0; i < 8; i++) begin
      rand_data(d1);
      send(2'($urandom_range(0, 3)), 32'($urandom_range(0, 3000)), d1);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
